wb_commit_ctrl: RTL
===================

Name: wb_commit_ctrl

Overview:
Sequences the write-back stage of the 16-bit single-issue core: accepts one retiring instruction at a time, waits for multi-cycle memory read data when needed, then commits the register-file write and PC update in a single registered cycle. Owns the pc / out_data select controls (Jump, MemToReg) and back-pressures the memory stage via in_ready. Adds a memory-wait watchdog and a sticky halt/error state.

Parameters:
DATA_W, 16, datapath and PC width
REG_ADDR_W, 3, register-file address width
MEM_TIMEOUT, 64, max cycles in WAIT_MEM before error; 0 disables watchdog

Ports:
clk  in  1  core clock
rst  in  1  asynchronous reset, active-low
in_valid  in  1  memory stage presents a retiring instruction
in_ready  out  1  controller can accept (state IDLE)
in_jump  in  1  select jump_addr for next PC
in_mem_to_reg  in  1  write-back data comes from memory
in_reg_write  in  1  instruction writes the register file
in_halt  in  1  instruction is HALT
in_write_reg  in  REG_ADDR_W  destination register
in_jump_addr  in  DATA_W  jump target
in_branch_or_pc  in  DATA_W  branch target or PC+2
in_alu_result  in  DATA_W  ALU result
mem_done  in  1  memory read data valid this cycle
mem_data  in  DATA_W  memory read data
pc_wr_en  out  1  one-cycle commit pulse for PC register
pc_next  out  DATA_W  committed next PC
rf_wr_en  out  1  one-cycle register-file write strobe
rf_wr_reg  out  REG_ADDR_W  register-file write address
rf_wr_data  out  DATA_W  register-file write data
halted  out  1  sticky, HALT committed
err  out  1  sticky, memory watchdog expired

Behaviour:
- Reset (rst low, async): state IDLE; all outputs 0; captured fields and watchdog counter 0.
- States: IDLE, WAIT_MEM, COMMIT, HALTED, ERROR.
- IDLE: in_ready=1. On in_valid: capture all in_* fields. Next state WAIT_MEM if in_mem_to_reg, otherwise COMMIT. mem_done is ignored in IDLE.
- WAIT_MEM: in_ready=0. Watchdog counter increments each cycle. On mem_done: capture mem_data, go to COMMIT. mem_done takes priority over watchdog expiry in the same cycle. If counter reaches MEM_TIMEOUT (nonzero): go to ERROR with no commit.
- COMMIT (one cycle): registered outputs are valid this cycle.
  - pc_wr_en=1.
  - pc_next = jump_addr if jump, else branch_or_pc.
  - rf_wr_en = reg_write.
  - rf_wr_data = captured mem_data if mem_to_reg, else alu_result.
  - rf_wr_reg = write_reg.
  - Next state: HALTED if halt, else IDLE.
- Outside COMMIT: pc_wr_en and rf_wr_en are 0. pc_next, rf_wr_reg and rf_wr_data hold their last values.
- Latency:
  - Non-memory op accepted in cycle N commits in cycle N+1. Next accept is no earlier than N+2, so throughput is one instruction per 2 cycles.
  - Memory op: mem_done in cycle M (M >= N+1) commits in cycle M+1.
- HALTED: halted=1, in_ready=0; terminal until reset. A HALT commits its PC update; it also commits a register write if reg_write is set.
- ERROR: err=1, in_ready=0; terminal until reset.
- Reset mid-WAIT_MEM or mid-COMMIT: transaction discarded, no pulse emitted.
- Watchdog counter is sized to hold MEM_TIMEOUT and saturates; it clears on every entry to WAIT_MEM.

Optional Feature:
WB_PERF_CNT_EN. When defined, adds outputs perf_retired[31:0] and perf_stall[31:0]:
- perf_retired increments on each COMMIT.
- perf_stall increments each WAIT_MEM cycle.
- Both saturate at all-ones and reset to 0.
When undefined, neither port nor logic exists and behaviour is otherwise identical.

Decomposition:
- Shared package wb_pkg: state enum (IDLE, WAIT_MEM, COMMIT, HALTED, ERROR), DATA_W, REG_ADDR_W defaults, captured-instruction struct typedef.
- One natural sub-module: wb_watchdog (load/enable/saturating counter with expired flag), reusable by the fetch stage.

Test Plan:
- ALU op: in_valid, jump=0, branch_or_pc=0x0012, alu_result=0xBEEF, reg_write=1, write_reg=3 -> next cycle pc_wr_en=1, pc_next=0x0012, rf_wr_en=1, rf_wr_reg=3, rf_wr_data=0xBEEF.
- Jump, no write: jump=1, jump_addr=0x0400, reg_write=0 -> commit pc_next=0x0400, rf_wr_en=0.
- Load with 3-cycle wait: mem_to_reg=1, mem_done with mem_data=0x1234 three cycles after accept -> in_ready=0 throughout; commit one cycle after mem_done with rf_wr_data=0x1234.
- Watchdog: MEM_TIMEOUT=4, load with no mem_done -> err=1 after 4 WAIT_MEM cycles, no pc_wr_en, in_ready stays 0. mem_done on the expiry cycle -> normal commit, err=0.
- HALT: halt=1, branch_or_pc=0x0020 -> commit pulse with pc_next=0x0020, then halted=1 and further in_valid ignored.
- Async reset asserted during WAIT_MEM -> outputs 0 immediately. After release, in_ready=1 and no stale commit.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types for the write-back stage: FSM state encoding and the
// captured retiring-instruction record.
package wb_pkg;

  localparam int unsigned WB_DATA_W     = 16;
  localparam int unsigned WB_REG_ADDR_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_MEM,
    ST_COMMIT,
    ST_HALTED,
    ST_ERROR
  } wb_state_e;

  typedef struct packed {
    logic                     jump;
    logic                     mem_to_reg;
    logic                     reg_write;
    logic                     halt;
    logic [WB_REG_ADDR_W-1:0] write_reg;
    logic [WB_DATA_W-1:0]     jump_addr;
    logic [WB_DATA_W-1:0]     branch_or_pc;
    logic [WB_DATA_W-1:0]     alu_result;
  } wb_instr_t;

endpackage

// File: rtl/wb_watchdog.sv
// Saturating wait counter: load clears, en counts, expired flags the
// LIMIT-th enabled cycle. LIMIT of 0 disables expiry.
module wb_watchdog #(
  parameter int unsigned LIMIT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int unsigned       CNT_W = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);
  localparam logic [CNT_W-1:0]  LAST  = (LIMIT == 0) ? '0 : CNT_W'(LIMIT - 1);
  localparam logic [CNT_W-1:0]  MAX   = CNT_W'(LIMIT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = '0;
    else if (en && (cnt_q != MAX))
      cnt_d = CNT_W'(cnt_q + 1'b1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // cnt_q counts completed enabled cycles, so the current one is the LIMIT-th
  assign expired = (LIMIT != 0) && en && (cnt_q == LAST);

endmodule

// File: rtl/wb_commit_ctrl.sv
// Write-back commit controller: capture, optional memory wait with watchdog,
// single registered commit cycle. `WB_PERF_CNT_EN adds retire/stall counters.
module wb_commit_ctrl
  import wb_pkg::*;
#(
  parameter int unsigned DATA_W      = WB_DATA_W,
  parameter int unsigned REG_ADDR_W  = WB_REG_ADDR_W,
  parameter int unsigned MEM_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_jump,
  input  logic                  in_mem_to_reg,
  input  logic                  in_reg_write,
  input  logic                  in_halt,
  input  logic [REG_ADDR_W-1:0] in_write_reg,
  input  logic [DATA_W-1:0]     in_jump_addr,
  input  logic [DATA_W-1:0]     in_branch_or_pc,
  input  logic [DATA_W-1:0]     in_alu_result,
  input  logic                  mem_done,
  input  logic [DATA_W-1:0]     mem_data,
  output logic                  pc_wr_en,
  output logic [DATA_W-1:0]     pc_next,
  output logic                  rf_wr_en,
  output logic [REG_ADDR_W-1:0] rf_wr_reg,
  output logic [DATA_W-1:0]     rf_wr_data,
`ifdef WB_PERF_CNT_EN
  output logic [31:0]           perf_retired,
  output logic [31:0]           perf_stall,
`endif
  output logic                  halted,
  output logic                  err
);

  wb_state_e             state_q, state_d;
  wb_instr_t             instr_q, instr_d;
  logic [DATA_W-1:0]     mem_data_q, mem_data_d;
  logic                  in_ready_q, in_ready_d;
  logic                  pc_wr_en_q, pc_wr_en_d;
  logic [DATA_W-1:0]     pc_next_q, pc_next_d;
  logic                  rf_wr_en_q, rf_wr_en_d;
  logic [REG_ADDR_W-1:0] rf_wr_reg_q, rf_wr_reg_d;
  logic [DATA_W-1:0]     rf_wr_data_q, rf_wr_data_d;
  logic                  halted_q, halted_d;
  logic                  err_q, err_d;
  logic                  accept;
  logic                  wd_expired;

  // in_ready is registered, so the first cycle after reset release never accepts
  assign accept = (state_q == ST_IDLE) && in_ready_q && in_valid;

  wb_watchdog #(.LIMIT(MEM_TIMEOUT)) u_watchdog (
    .clk     (clk),
    .rst_n   (rst),
    .load    (accept && in_mem_to_reg),
    .en      (state_q == ST_WAIT_MEM),
    .expired (wd_expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (accept) state_d = in_mem_to_reg ? ST_WAIT_MEM : ST_COMMIT;
      ST_WAIT_MEM: begin
        if (mem_done)        state_d = ST_COMMIT;
        else if (wd_expired) state_d = ST_ERROR;
      end
      ST_COMMIT:   state_d = instr_q.halt ? ST_HALTED : ST_IDLE;
      ST_HALTED:   state_d = ST_HALTED;
      ST_ERROR:    state_d = ST_ERROR;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    instr_d    = instr_q;
    mem_data_d = mem_data_q;
    if (accept) begin
      instr_d.jump         = in_jump;
      instr_d.mem_to_reg   = in_mem_to_reg;
      instr_d.reg_write    = in_reg_write;
      instr_d.halt         = in_halt;
      instr_d.write_reg    = in_write_reg;
      instr_d.jump_addr    = in_jump_addr;
      instr_d.branch_or_pc = in_branch_or_pc;
      instr_d.alu_result   = in_alu_result;
    end
    if ((state_q == ST_WAIT_MEM) && mem_done)
      mem_data_d = mem_data;
  end

  // Commit values are computed on entry so they are registered during COMMIT
  always_comb begin
    pc_wr_en_d   = (state_d == ST_COMMIT);
    pc_next_d    = pc_next_q;
    rf_wr_en_d   = 1'b0;
    rf_wr_reg_d  = rf_wr_reg_q;
    rf_wr_data_d = rf_wr_data_q;
    in_ready_d   = (state_d == ST_IDLE);
    halted_d     = (state_d == ST_HALTED);
    err_d        = (state_d == ST_ERROR);
    if (state_d == ST_COMMIT) begin
      pc_next_d    = instr_d.jump ? instr_d.jump_addr : instr_d.branch_or_pc;
      rf_wr_en_d   = instr_d.reg_write;
      rf_wr_reg_d  = instr_d.write_reg;
      rf_wr_data_d = instr_d.mem_to_reg ? mem_data_d : instr_d.alu_result;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_q      <= '0;
      mem_data_q   <= '0;
      in_ready_q   <= 1'b0;
      pc_wr_en_q   <= 1'b0;
      pc_next_q    <= '0;
      rf_wr_en_q   <= 1'b0;
      rf_wr_reg_q  <= '0;
      rf_wr_data_q <= '0;
      halted_q     <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      instr_q      <= instr_d;
      mem_data_q   <= mem_data_d;
      in_ready_q   <= in_ready_d;
      pc_wr_en_q   <= pc_wr_en_d;
      pc_next_q    <= pc_next_d;
      rf_wr_en_q   <= rf_wr_en_d;
      rf_wr_reg_q  <= rf_wr_reg_d;
      rf_wr_data_q <= rf_wr_data_d;
      halted_q     <= halted_d;
      err_q        <= err_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign pc_wr_en   = pc_wr_en_q;
  assign pc_next    = pc_next_q;
  assign rf_wr_en   = rf_wr_en_q;
  assign rf_wr_reg  = rf_wr_reg_q;
  assign rf_wr_data = rf_wr_data_q;
  assign halted     = halted_q;
  assign err        = err_q;

`ifdef WB_PERF_CNT_EN
  logic [31:0] retired_q, retired_d;
  logic [31:0] stall_q, stall_d;

  always_comb begin
    retired_d = retired_q;
    stall_d   = stall_q;
    if ((state_q == ST_COMMIT) && (retired_q != '1))
      retired_d = retired_q + 32'd1;
    if ((state_q == ST_WAIT_MEM) && (stall_q != '1))
      stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retired_q <= '0;
      stall_q   <= '0;
    end else begin
      retired_q <= retired_d;
      stall_q   <= stall_d;
    end
  end

  assign perf_retired = retired_q;
  assign perf_stall   = stall_q;
`endif

endmodule
